acq_ctrl: RTL and testbench

Acquisition controller that sequences the sample path (`sample_logic`) for one capture. It arms sampling on a host command, waits for a trigger (real or timeout-forced), counts a programmable number of post-trigger writes, then stops. It holds the capture until the host has drained the sample FIFO, and re-arms automatically in auto mode. It sits between the host command/status registers and `sample_logic`, driving its `acquiring_i` input.

---
 rtl/acq_pkg.sv | 25 ++
 rtl/acq_ctrl_sat_counter.sv | 39 +++
 rtl/acq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_acq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition controller: state encoding, default
// widths and a small helper that classifies states.
package acq_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_TO_W  = 24;

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_ARMED     = 2'b01;
    localparam logic [1:0] ST_TRIGGERED = 2'b10;
    localparam logic [1:0] ST_DONE      = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        ARMED     = ST_ARMED,
        TRIGGERED = ST_TRIGGERED,
        DONE      = ST_DONE
    } acq_state_e;

    // Sampling is enabled while waiting for a trigger and while counting writes.
    function automatic logic state_is_sampling(input logic [1:0] st);
        return (st == ST_ARMED) || (st == ST_TRIGGERED);
    endfunction

endpackage

// File: rtl/acq_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of
// wrapping, plus a compare against a caller-supplied terminal value.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         at_term_o
);

    logic [W-1:0] count_q, count_d;
    logic         sat;

    assign sat       = &count_q;
    assign at_term_o = (count_q == term_i);

    // NOTE: next-state is given a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !sat) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/acq_ctrl.sv
// Capture sequencer for sample_logic: arm, wait for a real or timeout-forced
// trigger, count post-trigger writes, then hold until the FIFO drains.
module acq_ctrl
    import acq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int TO_W  = DEF_TO_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             auto_i,
    input  logic [CNT_W-1:0] post_count_i,
    input  logic [TO_W-1:0]  timeout_i,
    input  logic             trigger_i,
    input  logic             w_en_i,
    input  logic             fifo_full_i,
    input  logic             fifo_empty_i,
    output logic             acquiring_o,
    output logic             busy_o,
    output logic             triggered_o,
    output logic             forced_o,
    output logic             truncated_o,
    output logic             done_o
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] post_q, post_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             triggered_q, triggered_d;
    logic             forced_q, forced_d;
    logic             truncated_q, truncated_d;
    logic             done_q, done_d;
    logic             acq_q, acq_d;
    logic             busy_q, busy_d;

    logic             arm_load;
    logic             post_en;
    logic             to_en;
    logic             post_at_term;
    logic             to_at_term;
    logic             to_expired;

    sat_counter #(.W(CNT_W)) u_post_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (arm_load),
        .en_i      (post_en),
        .term_i    (post_q - CNT_W'(1)),
        .at_term_o (post_at_term)
    );

    sat_counter #(.W(TO_W)) u_to_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (arm_load),
        .en_i      (to_en),
        .term_i    (to_q - TO_W'(1)),
        .at_term_o (to_expired)
    );

    // A zero timeout means wait forever, so the terminal compare is masked off.
    assign to_at_term = (to_q != '0) && to_expired;

    always_comb begin
        state_d     = state_q;
        post_d      = post_q;
        to_d        = to_q;
        triggered_d = triggered_q;
        forced_d    = forced_q;
        truncated_d = truncated_q;
        done_d      = 1'b0;
        arm_load    = 1'b0;
        post_en     = 1'b0;
        to_en       = 1'b0;

        if (abort_i) begin
            state_d     = ST_IDLE;
            triggered_d = 1'b0;
            forced_d    = 1'b0;
            truncated_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    arm_load = arm_i;
                end
                ST_ARMED: begin
                    if (trigger_i || to_at_term) begin
                        triggered_d = 1'b1;
                        forced_d    = !trigger_i;
                        if (post_q == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_TRIGGERED;
                        end
                    end else begin
                        to_en = 1'b1;
                    end
                end
                ST_TRIGGERED: begin
                    if (fifo_full_i) begin
                        state_d     = ST_DONE;
                        truncated_d = 1'b1;
                        done_d      = 1'b1;
                    end else if (w_en_i) begin
                        post_en = 1'b1;
                        if (post_at_term) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    // done_q is high only in the first DONE cycle, so it gates the drain check.
                    if (fifo_empty_i && !done_q) begin
                        if (auto_i) begin
                            arm_load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            endcase
        end

        if (arm_load) begin
            state_d     = ST_ARMED;
            post_d      = post_count_i;
            to_d        = timeout_i;
            triggered_d = 1'b0;
            forced_d    = 1'b0;
            truncated_d = 1'b0;
        end

        acq_d  = state_is_sampling(state_d);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            post_q      <= '0;
            to_q        <= '0;
            triggered_q <= 1'b0;
            forced_q    <= 1'b0;
            truncated_q <= 1'b0;
            done_q      <= 1'b0;
            acq_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            post_q      <= post_d;
            to_q        <= to_d;
            triggered_q <= triggered_d;
            forced_q    <= forced_d;
            truncated_q <= truncated_d;
            done_q      <= done_d;
            acq_q       <= acq_d;
            busy_q      <= busy_d;
        end
    end

    assign acquiring_o = acq_q;
    assign busy_o      = busy_q;
    assign triggered_o = triggered_q;
    assign forced_o    = forced_q;
    assign truncated_o = truncated_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_acq_ctrl.sv
// Self-checking bench for acq_ctrl: an event-level capture model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_acq_ctrl;

    localparam int CNT_W = 16;
    localparam int TO_W  = 24;

    logic             clk_i        = 1'b0;
    logic             rst_i        = 1'b1;
    logic             arm_i        = 1'b0;
    logic             abort_i      = 1'b0;
    logic             auto_i       = 1'b0;
    logic [CNT_W-1:0] post_count_i = '0;
    logic [TO_W-1:0]  timeout_i    = '0;
    logic             trigger_i    = 1'b0;
    logic             w_en_i       = 1'b0;
    logic             fifo_full_i  = 1'b0;
    logic             fifo_empty_i = 1'b0;
    logic             acquiring_o;
    logic             busy_o;
    logic             triggered_o;
    logic             forced_o;
    logic             truncated_o;
    logic             done_o;

    int n_checks  = 0;
    int n_fail    = 0;
    bit chk_en    = 1'b0;
    int done_seen = 0;
    int done_base = 0;

    acq_ctrl #(.CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .auto_i       (auto_i),
        .post_count_i (post_count_i),
        .timeout_i    (timeout_i),
        .trigger_i    (trigger_i),
        .w_en_i       (w_en_i),
        .fifo_full_i  (fifo_full_i),
        .fifo_empty_i (fifo_empty_i),
        .acquiring_o  (acquiring_o),
        .busy_o       (busy_o),
        .triggered_o  (triggered_o),
        .forced_o     (forced_o),
        .truncated_o  (truncated_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Capture model: tracks the capture as events (edges waited, writes seen,
    // edges spent draining) rather than as a state register.
    bit m_active  = 1'b0;
    bit m_in_done = 1'b0;
    bit m_trig    = 1'b0;
    bit m_forced  = 1'b0;
    bit m_trunc   = 1'b0;
    bit m_done    = 1'b0;
    int m_wait    = 0;
    int m_writes  = 0;
    int m_drain   = 0;
    int m_post    = 0;
    int m_to      = 0;

    function automatic void m_start();
        m_active  = 1'b1;
        m_in_done = 1'b0;
        m_trig    = 1'b0;
        m_forced  = 1'b0;
        m_trunc   = 1'b0;
        m_wait    = 0;
        m_writes  = 0;
        m_post    = int'(post_count_i);
        m_to      = int'(timeout_i);
    endfunction

    function automatic void m_finish(input bit trunc);
        m_active  = 1'b0;
        m_in_done = 1'b1;
        m_done    = 1'b1;
        m_trunc   = trunc;
        m_drain   = 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) begin
                m_active  = 1'b0;
                m_in_done = 1'b0;
                m_trig    = 1'b0;
                m_forced  = 1'b0;
                m_trunc   = 1'b0;
                m_done    = 1'b0;
            end else begin
                m_done = 1'b0;
                if (abort_i) begin
                    m_active  = 1'b0;
                    m_in_done = 1'b0;
                    m_trig    = 1'b0;
                    m_forced  = 1'b0;
                    m_trunc   = 1'b0;
                end else if (m_in_done) begin
                    m_drain++;
                    if (m_drain >= 2 && fifo_empty_i) begin
                        if (auto_i) m_start();
                        else        m_in_done = 1'b0;
                    end
                end else if (!m_active) begin
                    if (arm_i) m_start();
                end else if (!m_trig) begin
                    m_wait++;
                    if (trigger_i || (m_to != 0 && m_wait == m_to)) begin
                        m_trig   = 1'b1;
                        m_forced = !trigger_i;
                        if (m_post == 0) m_finish(1'b0);
                    end
                end else begin
                    if (fifo_full_i) begin
                        m_finish(1'b1);
                    end else if (w_en_i) begin
                        m_writes++;
                        if (m_writes == m_post) m_finish(1'b0);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (done_o === 1'b1) done_seen++;
            if (chk_en) begin
                check("model_acquiring", acquiring_o, m_active);
                check("model_busy",      busy_o,      m_active || m_in_done);
                check("model_triggered", triggered_o, m_trig);
                check("model_forced",    forced_o,    m_forced);
                check("model_truncated", truncated_o, m_trunc);
                check("model_done",      done_o,      m_done);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic drain();
        fifo_empty_i = 1'b1;
        tick(2);
        fifo_empty_i = 1'b0;
    endtask

    initial begin
        #1 chk_en = 1'b1;
        #1;
        check("reset_acquiring", acquiring_o, 1'b0);
        check("reset_busy",      busy_o,      1'b0);
        check("reset_done",      done_o,      1'b0);
        #10 rst_i = 1'b0;
        tick(1);

        // Single shot: 4 writes, real trigger three edges after arm.
        post_count_i = 16'd4; timeout_i = '0; auto_i = 1'b0;
        arm_i = 1'b1; tick(1); arm_i = 1'b0;
        check("ss_acq_after_arm", acquiring_o, 1'b1);
        check("ss_busy_after_arm", busy_o, 1'b1);
        tick(2);
        trigger_i = 1'b1; tick(1); trigger_i = 1'b0;
        check("ss_triggered", triggered_o, 1'b1);
        check("ss_not_forced", forced_o, 1'b0);
        w_en_i = 1'b1; tick(3);
        check("ss_no_done_before_4th", done_o, 1'b0);
        tick(1);
        check("ss_done_pulse", done_o, 1'b1);
        check("ss_acq_off", acquiring_o, 1'b0);
        w_en_i = 1'b0; fifo_empty_i = 1'b1; tick(1);
        check("ss_done_falls", done_o, 1'b0);
        check("ss_first_done_cycle_held", busy_o, 1'b1);
        tick(1); fifo_empty_i = 1'b0;
        check("ss_back_idle", busy_o, 1'b0);

        // Forced trigger after exactly 10 ARMED cycles.
        post_count_i = 16'd3; timeout_i = 24'd10;
        arm_i = 1'b1; tick(1); arm_i = 1'b0;
        tick(9);
        check("ft_not_yet", triggered_o, 1'b0);
        tick(1);
        check("ft_triggered", triggered_o, 1'b1);
        check("ft_forced", forced_o, 1'b1);
        w_en_i = 1'b1; tick(3); w_en_i = 1'b0;
        check("ft_done", done_o, 1'b1);
        drain();
        check("ft_idle", busy_o, 1'b0);

        // Real trigger in the expiry cycle wins, then abort in TRIGGERED.
        arm_i = 1'b1; tick(1); arm_i = 1'b0;
        tick(9);
        trigger_i = 1'b1; tick(1); trigger_i = 1'b0;
        check("fx_triggered", triggered_o, 1'b1);
        check("fx_not_forced", forced_o, 1'b0);
        abort_i = 1'b1; arm_i = 1'b1; tick(1); abort_i = 1'b0; arm_i = 1'b0;
        check("ab_acq", acquiring_o, 1'b0);
        check("ab_busy", busy_o, 1'b0);
        check("ab_no_done", done_o, 1'b0);
        check("ab_flags_clear", triggered_o, 1'b0);

        // Truncation; fifo_full while ARMED is ignored.
        post_count_i = 16'd100; timeout_i = '0;
        arm_i = 1'b1; tick(1); arm_i = 1'b0;
        fifo_full_i = 1'b1; tick(1); fifo_full_i = 1'b0;
        check("tr_full_ignored_armed", acquiring_o, 1'b1);
        trigger_i = 1'b1; tick(1); trigger_i = 1'b0;
        w_en_i = 1'b1; tick(7); w_en_i = 1'b0;
        fifo_full_i = 1'b1; tick(1); fifo_full_i = 1'b0;
        check("tr_done", done_o, 1'b1);
        check("tr_truncated", truncated_o, 1'b1);
        drain();

        // Zero post count: DONE straight from the trigger.
        post_count_i = '0;
        arm_i = 1'b1; tick(1); arm_i = 1'b0;
        trigger_i = 1'b1; tick(1); trigger_i = 1'b0;
        check("pz_done", done_o, 1'b1);
        check("pz_triggered", triggered_o, 1'b1);
        check("pz_acq_off", acquiring_o, 1'b0);
        drain();

        // Re-arm while busy is ignored: the original timeout of 5 still applies.
        post_count_i = 16'd2; timeout_i = 24'd5;
        arm_i = 1'b1; tick(1); arm_i = 1'b0;
        tick(2);
        arm_i = 1'b1; timeout_i = 24'd20; post_count_i = 16'd9; tick(1); arm_i = 1'b0;
        tick(1);
        check("rb_not_yet", triggered_o, 1'b0);
        tick(1);
        check("rb_forced_at_5", forced_o, 1'b1);
        w_en_i = 1'b1; tick(2); w_en_i = 1'b0;
        check("rb_done_after_2", done_o, 1'b1);
        drain();

        // Auto mode: three captures, one done pulse each, re-arm with flags cleared.
        auto_i = 1'b1; post_count_i = 16'd2; timeout_i = '0;
        done_base = done_seen;
        arm_i = 1'b1; tick(1); arm_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            trigger_i = 1'b1; tick(1); trigger_i = 1'b0;
            w_en_i = 1'b1; tick(2); w_en_i = 1'b0;
            check("au_done", done_o, 1'b1);
            drain();
            check("au_rearmed", acquiring_o, 1'b1);
            check("au_flags_clear", triggered_o, 1'b0);
        end
        check_int("au_done_count", done_seen - done_base, 3);
        auto_i = 1'b0;
        abort_i = 1'b1; tick(1); abort_i = 1'b0;
        check("au_abort_idle", busy_o, 1'b0);

        // Asynchronous reset between edges while ARMED.
        post_count_i = 16'd4;
        arm_i = 1'b1; tick(1); arm_i = 1'b0;
        tick(1);
        #2 rst_i = 1'b1;
        #1;
        check("rs_acq_immediate", acquiring_o, 1'b0);
        check("rs_busy_immediate", busy_o, 1'b0);
        @(negedge clk_i);
        #1 rst_i = 1'b0;
        tick(1);
        check("rs_stays_idle", busy_o, 1'b0);
        check("rs_no_done", done_o, 1'b0);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
